xor_accum_unit: RTL and testbench

- Parametrised successor of the fixed 32-bit registered XOR stage in the DES datapath.
- Runs in one of two modes:
  - Mode 0 (pairwise): XORs two WIDTH-bit operands per beat, as in a Feistel round-half combine.
  - Mode 1 (accumulate): XOR-folds a multi-beat frame of operand pairs into one result, used for CBC chaining and key-whitening across blocks.
- Uses valid/ready handshakes on both sides and emits a one-cycle finish pulse per result.
- Sits between the round-function output and the L/R register file.

---
 rtl/xor_accum_unit.sv | 73 +++++++
 tb/tb_xor_accum_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/xor_accum_unit.sv
// xor_accum_unit: registered XOR stage that combines operand pairs singly or folds multi-beat frames.
module xor_accum_unit #(
    parameter int WIDTH     = 32,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_trunc,
    output logic             finish
);
    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;
    state_t state, state_d;
    logic [WIDTH-1:0] acc, acc_d, data_d, n;
    logic [CNT_W-1:0] cnt, cnt_d, count_d, c;
    logic trunc_d, in_fire, out_fire, pair, at_max, done;
    assign out_valid = state == OUT;
    assign in_ready  = (state != OUT) | out_ready;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    // Outside ACCUM every accepted beat opens a fresh frame, so the fold starts from zero.
    assign pair   = (state != ACCUM) & ~in_mode;
    assign n      = (state == ACCUM ? acc : '0) ^ in_a ^ in_b;
    assign c      = (state == ACCUM ? cnt : '0) + CNT_W'(1);
    assign at_max = c == CNT_W'(MAX_BEATS);
    assign done   = pair | in_last | at_max;
    always_comb begin
        state_d = state;
        acc_d   = acc;
        cnt_d   = cnt;
        data_d  = out_data;
        count_d = out_count;
        trunc_d = out_trunc;
        if (out_fire) state_d = IDLE;
        if (in_fire) begin
            state_d = done ? OUT : ACCUM;
            acc_d   = done ? '0 : n;
            cnt_d   = done ? '0 : c;
            data_d  = done ? n : out_data;
            count_d = done ? c : out_count;
            trunc_d = done ? ~pair & ~in_last & at_max : out_trunc;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_trunc <= 1'b0;
            finish    <= 1'b0;
        end else begin
            state     <= state_d;
            acc       <= acc_d;
            cnt       <= cnt_d;
            out_data  <= data_d;
            out_count <= count_d;
            out_trunc <= trunc_d;
            finish    <= out_fire;
        end
    end
endmodule

// File: tb/tb_xor_accum_unit.sv
// tb_xor_accum_unit: directed vector table plus randomized frames against a frame-level reference model.
module tb_xor_accum_unit;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_mode, in_last, out_valid, out_ready, out_trunc, finish;
    logic [31:0] in_a, in_b, out_data;
    logic [4:0]  out_count;

    xor_accum_unit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_trunc(out_trunc), .finish(finish)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a, b;
        logic        mode, last, ov;
        logic [31:0] od;
        logic [4:0]  oc;
        logic        ot;
    } vec_t;
    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  c;
        logic        t;
    } exp_t;

    int passed = 0, total = 0;
    logic mon_en = 1'b0, sb_en = 1'b0;
    logic prev_fire = 1'b0, prev_hold = 1'b0, prev_trunc = 1'b0;
    logic [31:0] prev_data = '0;
    logic [4:0]  prev_count = '0;
    exp_t exp_q[$];
    logic        in_frame = 1'b0;
    logic [31:0] m_acc = '0;
    int          m_n = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        else passed++;
    endtask

    // Frame-level reference: fold beats with XOR, close on in_last, pairwise mode or 16 beats.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic mode, input logic last);
        if (!in_frame && !mode) begin
            exp_q.push_back('{a ^ b, 5'd1, 1'b0});
        end else begin
            m_acc = in_frame ? m_acc ^ a ^ b : a ^ b;
            m_n   = in_frame ? m_n + 1 : 1;
            in_frame = 1'b1;
            if (last || m_n == 16) begin
                exp_q.push_back('{m_acc, 5'(m_n), ~last});
                in_frame = 1'b0;
            end
        end
    endtask

    always @(negedge clk) if (mon_en) begin
        exp_t e;
        chk("finish", finish, prev_fire);
        if (prev_hold) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, prev_data);
            chk("hold_count", out_count, prev_count);
            chk("hold_trunc", out_trunc, prev_trunc);
        end
        if (sb_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("sb_data", out_data, e.d);
                chk("sb_count", out_count, e.c);
                chk("sb_trunc", out_trunc, e.t);
            end
        end
        prev_fire  = out_valid & out_ready;
        prev_hold  = out_valid & ~out_ready & rst_n;
        prev_data  = out_data;
        prev_count = out_count;
        prev_trunc = out_trunc;
    end

    task automatic apply(input vec_t v, input string nm);
        in_valid = 1'b1; in_a = v.a; in_b = v.b; in_mode = v.mode; in_last = v.last; out_ready = 1'b1;
        #1 chk({nm, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        chk({nm, "_valid"}, out_valid, v.ov);
        if (v.ov) begin
            chk({nm, "_data"}, out_data, v.od);
            chk({nm, "_count"}, out_count, v.oc);
            chk({nm, "_trunc"}, out_trunc, v.ot);
        end
    endtask

    task automatic idle_tick();
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000 $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        logic fired = 1'b0;
        vecs[0] = '{32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 1'b0, 1'b1, 32'hFF00FF00, 5'd1, 1'b0};
        vecs[1] = '{32'h1, 32'h2, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0};
        vecs[2] = '{32'h4, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0};
        vecs[3] = '{32'h10, 32'h20, 1'b0, 1'b1, 1'b1, 32'h3F, 5'd3, 1'b0};
        vecs[4] = '{32'h1, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1, 5'd1, 1'b0};
        vecs[5] = '{32'h2, 32'h0, 1'b0, 1'b1, 1'b1, 32'h2, 5'd1, 1'b0};
        vecs[6] = '{32'h3, 32'h1, 1'b0, 1'b0, 1'b1, 32'h2, 5'd1, 1'b0};
        vecs[7] = '{32'hAA, 32'h55, 1'b0, 1'b0, 1'b1, 32'hFF, 5'd1, 1'b0};
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_count", out_count, 0);
        chk("rst_trunc", out_trunc, 0);
        chk("rst_finish", finish, 0);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", in_ready, 1);
        mon_en = 1'b1;
        for (int i = 0; i < 8; i++) apply(vecs[i], $sformatf("vec%0d", i));
        idle_tick();
        for (int i = 0; i < 16; i++)
            apply('{32'h1, 32'h0, 1'b1, 1'b0, i == 15, 32'h0, 5'd16, 1'b1}, $sformatf("trunc%0d", i));
        apply('{32'h7, 32'h0, 1'b1, 1'b1, 1'b1, 32'h7, 5'd1, 1'b0}, "after_trunc");
        idle_tick();
        in_valid = 1'b1; in_a = 32'h9; in_b = 32'h6; in_mode = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        chk("bp_first_valid", out_valid, 1);
        chk("bp_first_data", out_data, 32'hF);
        in_a = 32'h3; in_b = 32'h5;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_data", out_data, 32'hF);
            chk("bp_count", out_count, 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("bp_next_valid", out_valid, 1);
        chk("bp_next_data", out_data, 32'h6);
        chk("bp_next_count", out_count, 1);
        idle_tick();
        apply('{32'h1, 32'h2, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0}, "rf_beat1");
        apply('{32'h4, 32'h8, 1'b1, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0}, "rf_beat2");
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rf_valid", out_valid, 0);
        chk("rf_data", out_data, 0);
        chk("rf_count", out_count, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 chk("rf_in_ready", in_ready, 1);
        apply('{32'h5, 32'h3, 1'b0, 1'b0, 1'b1, 32'h6, 5'd1, 1'b0}, "rf_after");
        idle_tick();
        sb_en = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if (!in_valid || fired) begin
                in_valid = ($urandom % 4) != 0;
                in_a = $urandom; in_b = $urandom;
                in_mode = 1'($urandom % 2);
                in_last = ($urandom % 6) == 0;
            end
            out_ready = ($urandom % 4) != 0;
            @(negedge clk);
            fired = in_valid && in_ready;
            if (fired) model(in_a, in_b, in_mode, in_last);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1 chk("drain_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
